// File: rtl/keypad_scanner_if.sv
// Front-panel keypad link: matrix drive/sense plus the decoded key levels
// presented to the microwave controller.
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic [4:0] key_code;
    logic       key_strobe;

    // Scanner side: senses columns, drives rows and the key outputs.
    modport master (
        input  col_n,
        output row_n,
        output keypad,
        output startn,
        output stopn,
        output clearn,
        output key_code,
        output key_strobe
    );

    // Panel / controller side.
    modport slave (
        output col_n,
        input  row_n,
        input  keypad,
        input  startn,
        input  stopn,
        input  clearn,
        input  key_code,
        input  key_strobe
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: drives one row low at a time, samples the
// synchronized columns late in each row slot, reduces a full scan to a single
// key index (multi-press counts as release), debounces over whole scans and
// presents registered decodes of the accepted key.
//
// Scan vector bit 4*row+col is set when that key reads pressed.
// Code 16 means "no key".
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input logic        clock,
    input logic        resetn,
    keypad_scanner_if.master kp
);

    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int             DW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0]  SLOT_END = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  DEB_MAX  = DW'(DEBOUNCE_SCANS);
    localparam logic [4:0]     NO_KEY   = 5'd16;

    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] slot_q, slot_d;
    logic [3:0]    row_n_q, row_n_d;
    logic [15:0]   scan_q, scan_d;
    logic [4:0]    prev_q, prev_d;
    logic [DW-1:0] stable_q, stable_d;
    logic [4:0]    accepted_q, accepted_d;
    logic [9:0]    keypad_q, keypad_d;
    logic          startn_q, startn_d;
    logic          stopn_q, stopn_d;
    logic          clearn_q, clearn_d;
    logic [4:0]    key_code_q, key_code_d;
    logic          key_strobe_q, key_strobe_d;

    logic          sample;
    logic          scan_end;
    logic [4:0]    ones;
    logic [4:0]    idx;
    logic [4:0]    raw;

    // Two-flop synchronizer for the asynchronous column inputs; idle is all-high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= kp.col_n;
            sync2_q <= sync1_q;
        end
    end

    // Row/slot sequencing and capture of the current row's columns into the scan vector.
    always_comb begin
        sample   = (slot_q == SLOT_END);
        scan_end = sample && (row_q == 2'd3);
        slot_d   = sample ? '0 : slot_q + CW'(1);
        row_d    = sample ? row_q + 2'd1 : row_q;
        row_n_d  = ~(4'b0001 << row_d);
        scan_d   = scan_q;
        if (sample) begin
            scan_d[{row_q, 2'b00} +: 4] = ~sync2_q;
        end
    end

    // Reduce the completed scan (including the row-3 sample taken this edge) to one index.
    always_comb begin
        ones = 5'd0;
        idx  = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (scan_d[i]) begin
                ones = ones + 5'd1;
                idx  = 5'(i);
            end
        end
        raw = (ones == 5'd1) ? idx : NO_KEY;
    end

    // Debounce: a code must repeat on DEBOUNCE_SCANS consecutive scans to be accepted.
    always_comb begin
        prev_d     = prev_q;
        stable_d   = stable_q;
        accepted_d = accepted_q;
        if (scan_end) begin
            if (raw == prev_q) begin
                if (stable_q != DEB_MAX) begin
                    stable_d = stable_q + DW'(1);
                end
            end else begin
                prev_d   = raw;
                stable_d = DW'(1);
            end
            if ((stable_d == DEB_MAX) && (raw != accepted_q)) begin
                accepted_d = raw;
            end
        end
    end

    // Output decode of the accepted code; the strobe fires when a new real key lands.
    always_comb begin
        keypad_d     = '0;
        startn_d     = 1'b1;
        stopn_d      = 1'b1;
        clearn_d     = 1'b1;
        key_code_d   = accepted_q;
        key_strobe_d = (accepted_q != key_code_q) && (accepted_q != NO_KEY);
        case (accepted_q)
            5'd0:    keypad_d[1] = 1'b1;
            5'd1:    keypad_d[2] = 1'b1;
            5'd2:    keypad_d[3] = 1'b1;
            5'd3:    startn_d    = 1'b0;
            5'd4:    keypad_d[4] = 1'b1;
            5'd5:    keypad_d[5] = 1'b1;
            5'd6:    keypad_d[6] = 1'b1;
            5'd7:    stopn_d     = 1'b0;
            5'd8:    keypad_d[7] = 1'b1;
            5'd9:    keypad_d[8] = 1'b1;
            5'd10:   keypad_d[9] = 1'b1;
            5'd11:   clearn_d    = 1'b0;
            5'd13:   keypad_d[0] = 1'b1;
            default: ;
        endcase
    end

    // Scan and debounce state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            row_q      <= 2'd0;
            slot_q     <= '0;
            row_n_q    <= 4'b1110;
            scan_q     <= '0;
            prev_q     <= NO_KEY;
            stable_q   <= '0;
            accepted_q <= NO_KEY;
        end else begin
            row_q      <= row_d;
            slot_q     <= slot_d;
            row_n_q    <= row_n_d;
            scan_q     <= scan_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            accepted_q <= accepted_d;
        end
    end

    // Registered outputs, released immediately on reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            keypad_q     <= '0;
            startn_q     <= 1'b1;
            stopn_q      <= 1'b1;
            clearn_q     <= 1'b1;
            key_code_q   <= NO_KEY;
            key_strobe_q <= 1'b0;
        end else begin
            keypad_q     <= keypad_d;
            startn_q     <= startn_d;
            stopn_q      <= stopn_d;
            clearn_q     <= clearn_d;
            key_code_q   <= key_code_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    assign kp.row_n      = row_n_q;
    assign kp.keypad     = keypad_q;
    assign kp.startn     = startn_q;
    assign kp.stopn      = stopn_q;
    assign kp.clearn     = clearn_q;
    assign kp.key_code   = key_code_q;
    assign kp.key_strobe = key_strobe_q;

endmodule
